axis_frame_gen: RTL and testbench
=================================

# axis_frame_gen

Synthesisable, parametrised AXI-Stream Ethernet frame generator that drives the MAC TX user interface (`tx_axis_mac_*`) with configurable header, length, count, inter-frame gap and error injection. It sits in front of `mac10gbe` in on-chip loopback and bring-up designs and replaces hand-sequenced benches. The FCS is not generated; the MAC appends it.

## Interface
- `DATA_W`, 64, stream width in bits; legal values are 32, 64 and 128.
- `KEEP_W`, DATA_W/8, byte lanes.
- `LEN_W`, 14, width of the frame length field.
- `MAX_LEN`, 9596, upper clamp for the frame length in bytes, excluding FCS.
- `CNT_W`, 32, width of the statistics counters.
- `mac10gbe_clk`  in  1  the only clock.
- `mac_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches all `cfg_*` and begins a run. Ignored while `busy`.
- `stop`  in  1  one-cycle pulse; finishes the current frame, then ends the run.
- `cfg_dst_mac`, `cfg_src_mac`  in  48  MAC addresses; bits [47:40] are sent first.
- `cfg_ethertype`  in  16  EtherType; bits [15:8] are sent first.
- `cfg_frame_len`  in  LEN_W  frame bytes, header plus payload, excluding FCS.
- `cfg_frame_count`  in  16  frames per run; 0 means run until `stop`.
- `cfg_ifg_cycles`  in  8  idle cycles between frames.
- `cfg_err_every`  in  8  assert tuser on every Nth frame; 0 means never.
- `tx_axis_mac_tdata`  out  DATA_W  byte k of a beat is on bits [8k+7:8k].
- `tx_axis_mac_tkeep`  out  KEEP_W  byte-lane enables.
- `tx_axis_mac_tvalid`, `tx_axis_mac_tlast`, `tx_axis_mac_tuser`  out  1  AXI-Stream controls.
- `tx_axis_mac_tready`  in  1  sink ready.
- `busy`  out  1  high from the cycle after `start` until the run ends.
- `done`  out  1  one-cycle pulse when the run ends.
- `frames_sent`  out  CNT_W  count of frames whose tlast beat was accepted. Cleared on `start`, wraps.
- `bytes_sent`  out  CNT_W  sum of accepted frame lengths. Cleared on `start`, wraps.

## Operation
- States:
  - IDLE → DATA on `start`.
  - DATA → GAP on accepted tlast when `cfg_ifg_cycles` is nonzero and the run continues.
  - DATA → DATA on accepted tlast when `cfg_ifg_cycles` is 0 and the run continues.
  - DATA → IDLE on accepted tlast when the run ends.
  - GAP → DATA after `cfg_ifg_cycles` cycles.
  - GAP → IDLE if a stop is pending.
- Run end: `frames_sent` reaches a nonzero `cfg_frame_count`, or a stop is pending at a frame boundary. `done` pulses in the cycle the state returns to IDLE.
- A `stop` in IDLE is ignored. A `stop` during DATA or GAP sets a sticky stop flag, which is cleared on entering IDLE.
- Length L = clamp(`cfg_frame_len`, 60, `MAX_LEN`), computed when `start` latches the configuration.
- Beats per frame = ceil(L/KEEP_W). Every beat has `tkeep` all ones except the last.
- Last-beat `tkeep` = (1<<(L mod KEEP_W))−1, or all ones when L mod KEEP_W = 0.
- Byte index i = beat·KEEP_W + lane:
  - i 0–5: destination MAC.
  - i 6–11: source MAC.
  - i 12–13: EtherType.
  - i ≥ 14: (i−14)[7:0], an incrementing payload.
  - Lanes beyond L are driven to 0.
- `tuser` is high only on the tlast beat of frame n (1-based within the run) when `cfg_err_every` ≠ 0 and n mod `cfg_err_every` = 0.
- AXI rule: once `tvalid` is high, `tdata`, `tkeep`, `tlast` and `tuser` hold until `tready`. `tvalid` never drops mid-frame.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset mid-frame aborts immediately; `tvalid` goes to 0 asynchronously.
- All outputs are registered.
- `start` in cycle N: `busy` and the first beat's `tvalid` are asserted in cycle N+1.
- A beat transfers in a cycle where `tvalid` and `tready` are both high. The next beat is presented in the following cycle, giving 1 beat per cycle at `tready`=1.
- `cfg_ifg_cycles` = 0: the next frame's first beat is valid in the cycle after tlast is accepted, with no bubble.
- `cfg_ifg_cycles` = G: exactly G cycles with `tvalid`=0 between frames.
- Counters update in the cycle after the tlast handshake.
- `busy` falls in the same cycle `done` pulses.
- `start` coinciding with `done`: the `start` is ignored.
- `start` and `stop` in the same IDLE cycle: the run starts and ends after the first frame.

## Test plan
- DATA_W=64; L=60; dst FF:FF:FF:FF:FF:FF; src 11:22:33:44:55:66; count 1; `tready`=1 → 8 beats.
  - Beat 0 = 64'h2211FFFFFFFFFFFF.
  - Beat 7 has `tkeep`=8'h0F and `tlast`=1.
  - `frames_sent`=1, `bytes_sent`=60, one `done` pulse.
- `cfg_frame_len`=20 → clamped to 60. `cfg_frame_len`=64 → 8 beats, last `tkeep`=8'hFF.
- Random `tready` (50%) on a 1514-byte frame → no payload byte skipped or repeated. Beat count is 190. Outputs stay stable while stalled.
- count=4, ifg=2, err_every=2 → exactly 2 idle cycles between frames. `tuser` is high on the tlast of frames 2 and 4 only. `frames_sent`=4.
- count=0, `stop` pulsed mid-frame 3 → frame 3 completes, then IDLE. `done` pulses once, `frames_sent`=3.
- Reset asserted mid-frame → `tvalid`=0 and all counters 0 immediately. A later `start` produces a clean frame starting at beat 0.

Source files
------------

// File: rtl/axis_frame_gen.sv
// axis_frame_gen
// ---------------------------------------------------------------------------
// Generates a run of Ethernet frames (without FCS) on an AXI-Stream master
// port that feeds the MAC TX user interface. The header (dst MAC, src MAC,
// EtherType), frame length, frame count, inter-frame gap and tuser error
// injection rate are all latched from cfg_* when `start` is accepted.
//
// Ports
//   mac10gbe_clk, mac_reset_n : clock, asynchronous active-low reset
//   start, stop               : one-cycle run control pulses
//   cfg_*                     : run configuration, sampled on accepted start
//   tx_axis_mac_*             : AXI-Stream master (tdata/tkeep/tvalid/tlast/tuser, tready in)
//   busy, done                : run in progress / one-cycle end-of-run pulse
//   frames_sent, bytes_sent   : per-run statistics, cleared on start, wrapping
//   dbg_state                 : current FSM state (0 IDLE, 1 DATA, 2 GAP)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. While tvalid is high and tready is low, tdata/tkeep/tlast/tuser
// are held unchanged; tvalid never drops between the first and last beat of
// a frame.
// ---------------------------------------------------------------------------
module axis_frame_gen #(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int LEN_W   = 14,
    parameter int MAX_LEN = 9596,
    parameter int CNT_W   = 32
) (
    input  logic              mac10gbe_clk,
    input  logic              mac_reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [47:0]       cfg_dst_mac,
    input  logic [47:0]       cfg_src_mac,
    input  logic [15:0]       cfg_ethertype,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [15:0]       cfg_frame_count,
    input  logic [7:0]        cfg_ifg_cycles,
    input  logic [7:0]        cfg_err_every,
    output logic [DATA_W-1:0] tx_axis_mac_tdata,
    output logic [KEEP_W-1:0] tx_axis_mac_tkeep,
    output logic              tx_axis_mac_tvalid,
    output logic              tx_axis_mac_tlast,
    output logic              tx_axis_mac_tuser,
    input  logic              tx_axis_mac_tready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frames_sent,
    output logic [CNT_W-1:0]  bytes_sent,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(60);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] KEEP_C    = LEN_W'(KEEP_W);

    state_t              state_q, state_d;
    logic [47:0]         dst_q, dst_d, src_q, src_d;
    logic [15:0]         et_q, et_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [15:0]         count_q, count_d;
    logic [7:0]          ifg_q, ifg_d;
    logic [7:0]          every_q, every_d;
    logic [LEN_W-1:0]    off_q, off_d;      // byte index of the next beat to load
    logic [7:0]          gap_q, gap_d;
    logic [7:0]          err_cnt_q, err_cnt_d; // 1-based frame position within the error period
    logic                stop_q, stop_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic                tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]    frames_q, frames_d, bytes_q, bytes_d;

    logic                accept;
    logic [LEN_W-1:0]    cfg_len_clamped;

    assign accept = tvalid_q & tx_axis_mac_tready;

    always_comb begin
        cfg_len_clamped = cfg_frame_len;
        if (cfg_frame_len < MIN_LEN_C)      cfg_len_clamped = MIN_LEN_C;
        else if (cfg_frame_len > MAX_LEN_C) cfg_len_clamped = MAX_LEN_C;
    end

    // Beat builder. In IDLE the only beat that can be loaded is the first
    // beat of a run, which must come straight from cfg_* because the latched
    // copies are not written until the same edge. Mid-frame the next beat
    // starts at off_q; any other load starts a new frame at byte 0.
    logic                load_cfg;
    logic [LEN_W-1:0]    load_off;
    logic [47:0]         b_dst, b_src;
    logic [15:0]         b_et;
    logic [LEN_W-1:0]    b_len;
    logic [7:0]          b_every;
    logic [DATA_W-1:0]   b_data;
    logic [KEEP_W-1:0]   b_keep;
    logic                b_last;
    int                  idx;
    logic [7:0]          bval;

    always_comb begin
        load_cfg = (state_q == S_IDLE);
        load_off = (state_q == S_DATA && !tlast_q) ? off_q : '0;
        b_dst    = load_cfg ? cfg_dst_mac     : dst_q;
        b_src    = load_cfg ? cfg_src_mac     : src_q;
        b_et     = load_cfg ? cfg_ethertype   : et_q;
        b_len    = load_cfg ? cfg_len_clamped : len_q;
        b_every  = load_cfg ? cfg_err_every   : every_q;
        b_data   = '0;
        b_keep   = '0;
        idx      = 0;
        bval     = 8'h00;
        for (int k = 0; k < KEEP_W; k++) begin
            idx  = int'(load_off) + k;
            bval = 8'h00;
            if (idx < int'(b_len)) begin
                b_keep[k] = 1'b1;
                if (idx < 6)       bval = 8'(b_dst >> (8 * (5 - idx)));
                else if (idx < 12) bval = 8'(b_src >> (8 * (11 - idx)));
                else if (idx < 14) bval = 8'(b_et >> (8 * (13 - idx)));
                else               bval = 8'(idx - 14);
            end
            b_data[8*k +: 8] = bval;
        end
        b_last = (int'(load_off) + KEEP_W) >= int'(b_len);
    end

    logic             stop_pending, run_end, load, finish, clear;
    logic [CNT_W-1:0] frames_inc;
    logic [7:0]       err_next;

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        src_d     = src_q;
        et_d      = et_q;
        len_d     = len_q;
        count_d   = count_q;
        ifg_d     = ifg_q;
        every_d   = every_q;
        off_d     = off_q;
        gap_d     = gap_q;
        err_cnt_d = err_cnt_q;
        stop_d    = stop_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        frames_d  = frames_q;
        bytes_d   = bytes_q;
        load      = 1'b0;
        finish    = 1'b0;
        clear     = 1'b0;

        stop_pending = stop_q | stop;
        frames_inc   = frames_q + CNT_W'(1);
        run_end      = ((count_q != 16'd0) && (frames_inc == CNT_W'(count_q))) || stop_pending;
        err_next     = (err_cnt_q == every_q) ? 8'd1 : err_cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                // done_q is high in the first IDLE cycle; a start then is dropped.
                if (start && !done_q) begin
                    dst_d     = cfg_dst_mac;
                    src_d     = cfg_src_mac;
                    et_d      = cfg_ethertype;
                    len_d     = cfg_len_clamped;
                    count_d   = cfg_frame_count;
                    ifg_d     = cfg_ifg_cycles;
                    every_d   = cfg_err_every;
                    frames_d  = '0;
                    bytes_d   = '0;
                    stop_d    = stop;   // start+stop together: one frame only
                    err_cnt_d = 8'd1;
                    off_d     = KEEP_C;
                    busy_d    = 1'b1;
                    state_d   = S_DATA;
                    load      = 1'b1;
                end
            end
            S_DATA: begin
                if (stop) stop_d = 1'b1;
                if (accept) begin
                    if (!tlast_q) begin
                        load  = 1'b1;
                        off_d = off_q + KEEP_C;
                    end else begin
                        frames_d = frames_inc;
                        bytes_d  = bytes_q + CNT_W'(len_q);
                        if (run_end) begin
                            finish = 1'b1;
                        end else if (ifg_q == 8'd0) begin
                            load      = 1'b1;
                            err_cnt_d = err_next;
                            off_d     = KEEP_C;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = ifg_q;
                            clear   = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (stop_pending) begin
                    finish = 1'b1;
                end else if (gap_q <= 8'd1) begin
                    // Loading on the last gap cycle makes tvalid rise right after it.
                    load      = 1'b1;
                    err_cnt_d = err_next;
                    off_d     = KEEP_C;
                    state_d   = S_DATA;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                finish = 1'b1;
            end
        endcase

        if (finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
            clear   = 1'b1;
        end
        if (clear) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = b_data;
            tkeep_d  = b_keep;
            tlast_d  = b_last;
            tuser_d  = b_last && (b_every != 8'd0) && (err_cnt_d == b_every);
        end
    end

    always_ff @(posedge mac10gbe_clk or negedge mac_reset_n) begin
        if (!mac_reset_n) begin
            state_q   <= S_IDLE;
            dst_q     <= '0;
            src_q     <= '0;
            et_q      <= '0;
            len_q     <= '0;
            count_q   <= '0;
            ifg_q     <= '0;
            every_q   <= '0;
            off_q     <= '0;
            gap_q     <= '0;
            err_cnt_q <= '0;
            stop_q    <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            frames_q  <= '0;
            bytes_q   <= '0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            et_q      <= et_d;
            len_q     <= len_d;
            count_q   <= count_d;
            ifg_q     <= ifg_d;
            every_q   <= every_d;
            off_q     <= off_d;
            gap_q     <= gap_d;
            err_cnt_q <= err_cnt_d;
            stop_q    <= stop_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            frames_q  <= frames_d;
            bytes_q   <= bytes_d;
        end
    end

    assign tx_axis_mac_tdata  = tdata_q;
    assign tx_axis_mac_tkeep  = tkeep_q;
    assign tx_axis_mac_tvalid = tvalid_q;
    assign tx_axis_mac_tlast  = tlast_q;
    assign tx_axis_mac_tuser  = tuser_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign frames_sent        = frames_q;
    assign bytes_sent         = bytes_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Testbench for axis_frame_gen (DATA_W=64). Expected beats come from a
// byte-list frame model; a sink process drives tready and compares every
// accepted beat against the expected queue.
module tb_axis_frame_gen;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int LEN_W  = 14;
    localparam int CNT_W  = 32;
    localparam int EW     = DATA_W + KEEP_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0, stop = 1'b0;
    logic [47:0]       cfg_dst_mac = '0, cfg_src_mac = '0;
    logic [15:0]       cfg_ethertype = '0;
    logic [LEN_W-1:0]  cfg_frame_len = '0;
    logic [15:0]       cfg_frame_count = '0;
    logic [7:0]        cfg_ifg_cycles = '0, cfg_err_every = '0;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid, tlast, tuser;
    logic              tready = 1'b0;
    logic              busy, done;
    logic [CNT_W-1:0]  frames_sent, bytes_sent;
    logic [1:0]        dbg_state;

    axis_frame_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .mac10gbe_clk       (clk),
        .mac_reset_n        (rst_n),
        .start              (start),
        .stop               (stop),
        .cfg_dst_mac        (cfg_dst_mac),
        .cfg_src_mac        (cfg_src_mac),
        .cfg_ethertype      (cfg_ethertype),
        .cfg_frame_len      (cfg_frame_len),
        .cfg_frame_count    (cfg_frame_count),
        .cfg_ifg_cycles     (cfg_ifg_cycles),
        .cfg_err_every      (cfg_err_every),
        .tx_axis_mac_tdata  (tdata),
        .tx_axis_mac_tkeep  (tkeep),
        .tx_axis_mac_tvalid (tvalid),
        .tx_axis_mac_tlast  (tlast),
        .tx_axis_mac_tuser  (tuser),
        .tx_axis_mac_tready (tready),
        .busy               (busy),
        .done               (done),
        .frames_sent        (frames_sent),
        .bytes_sent         (bytes_sent),
        .dbg_state          (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    int gap_q[$];
    int beats_acc, tuser_acc, done_cnt, gap_cnt;
    logic gap_track, first_seen;
    logic [DATA_W-1:0] first_data;
    logic [KEEP_W-1:0] last_keep;
    int ready_mode = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < 60) return 60;
        if (l > 9596) return 9596;
        return l;
    endfunction

    // Frame model: build the byte list from the header fields and payload
    // rule, then cut it into KEEP_W-byte beats.
    task automatic model_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                               input int len_raw, input int n, input int every);
        logic [7:0] b[$];
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic last, user;
        int l;
        l = clamp_len(len_raw);
        for (int i = 0; i < 6; i++) b.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(s[47-8*i -: 8]);
        b.push_back(et[15:8]);
        b.push_back(et[7:0]);
        for (int i = 14; i < l; i++) b.push_back(8'(i - 14));
        while (b.size() > 0) begin
            data = '0;
            keep = '0;
            for (int k = 0; k < KEEP_W; k++) begin
                if (b.size() > 0) begin
                    data[8*k +: 8] = b.pop_front();
                    keep[k] = 1'b1;
                end
            end
            last = (b.size() == 0);
            user = last && (every != 0) && ((n % every) == 0);
            exp_q.push_back({user, last, keep, data});
        end
    endtask

    // ---------------- sink / compare process ----------------
    logic prev_stall = 1'b0;
    logic [EW:0] prev_out = '0;
    logic [EW-1:0] cur;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                tready = 1'b1;
            end else begin
                tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                cur = {tuser, tlast, tkeep, tdata};
                if (prev_stall) chk("hold_while_stalled", {tvalid, cur}, prev_out);
                if (done) begin
                    done_cnt++;
                    chk("busy_low_with_done", busy, 0);
                end
                if (tvalid) begin
                    if (gap_track) begin
                        gap_q.push_back(gap_cnt);
                        gap_track = 1'b0;
                    end
                    if (tready) begin
                        beats_acc++;
                        if (!first_seen) begin
                            first_data = tdata;
                            first_seen = 1'b1;
                        end
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL beat: got %0h expected no beat", cur);
                        end else begin
                            chk("beat", cur, exp_q.pop_front());
                        end
                        if (tlast) begin
                            last_keep = tkeep;
                            gap_track = 1'b1;
                            gap_cnt = 0;
                            if (tuser) tuser_acc++;
                        end
                    end
                end else if (gap_track) begin
                    gap_cnt++;
                end
                prev_stall = tvalid && !tready;
                prev_out = {tvalid, cur};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                             input int len, input int count, input int ifg, input int every,
                             input logic with_stop);
        @(negedge clk);
        cfg_dst_mac = d;
        cfg_src_mac = s;
        cfg_ethertype = et;
        cfg_frame_len = LEN_W'(len);
        cfg_frame_count = 16'(count);
        cfg_ifg_cycles = 8'(ifg);
        cfg_err_every = 8'(every);
        beats_acc = 0;
        tuser_acc = 0;
        done_cnt = 0;
        gap_track = 1'b0;
        first_seen = 1'b0;
        gap_q.delete();
        start = 1'b1;
        stop = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("tvalid_after_start", tvalid, 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_beats(input int nb, input int budget);
        int n;
        n = 0;
        while (beats_acc < nb && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (beats_acc < nb) begin
            checks++;
            errors++;
            $display("FAIL wait_beats: got %0d beats expected %0d", beats_acc, nb);
        end
    endtask

    // ---------------- directed tests ----------------
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_A = 48'h1122_3344_5566;
    localparam logic [15:0] ET_IP = 16'h0800;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_bytes", bytes_sent, 0);
        chk("rst_tdata", {tuser, tlast, tkeep, tdata}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single minimum frame
        model_frame(BCAST, SRC_A, ET_IP, 60, 1, 0);
        start_run(BCAST, SRC_A, ET_IP, 60, 1, 0, 0, 1'b0);
        wait_done(100);
        chk("t1_beat0", first_data, 64'h2211FFFFFFFFFFFF);
        chk("t1_beats", beats_acc, 8);
        chk("t1_last_keep", last_keep, 8'h0F);
        chk("t1_frames", frames_sent, 1);
        chk("t1_bytes", bytes_sent, 60);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // length clamped up to 60
        model_frame(BCAST, SRC_A, ET_IP, 20, 1, 0);
        start_run(BCAST, SRC_A, ET_IP, 20, 1, 0, 0, 1'b0);
        wait_done(100);
        chk("t2_beats", beats_acc, 8);
        chk("t2_bytes", bytes_sent, 60);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 64 bytes: full last beat
        model_frame(SRC_A, BCAST, 16'h88B5, 64, 1, 0);
        start_run(SRC_A, BCAST, 16'h88B5, 64, 1, 0, 0, 1'b0);
        wait_done(100);
        chk("t3_beats", beats_acc, 8);
        chk("t3_last_keep", last_keep, 8'hFF);
        chk("t3_bytes", bytes_sent, 64);

        // 1514-byte frame with random backpressure
        ready_mode = 1;
        model_frame(BCAST, SRC_A, ET_IP, 1514, 1, 0);
        start_run(BCAST, SRC_A, ET_IP, 1514, 1, 0, 0, 1'b0);
        wait_done(3000);
        ready_mode = 0;
        chk("t4_beats", beats_acc, 190);
        chk("t4_last_keep", last_keep, 8'h03);
        chk("t4_bytes", bytes_sent, 1514);
        chk("t4_queue_empty", exp_q.size(), 0);

        // four frames, gap 2, error every 2nd frame
        for (int n = 1; n <= 4; n++) model_frame(BCAST, SRC_A, ET_IP, 60, n, 2);
        start_run(BCAST, SRC_A, ET_IP, 60, 4, 2, 2, 1'b0);
        wait_done(200);
        chk("t5_gap_count", gap_q.size(), 3);
        for (int g = 0; g < gap_q.size(); g++) chk("t5_gap_len", gap_q[g], 2);
        chk("t5_tuser_frames", tuser_acc, 2);
        chk("t5_frames", frames_sent, 4);
        chk("t5_bytes", bytes_sent, 240);
        chk("t5_queue_empty", exp_q.size(), 0);

        // endless run stopped in the middle of frame 3
        for (int n = 1; n <= 3; n++) model_frame(BCAST, SRC_A, ET_IP, 60, n, 3);
        start_run(BCAST, SRC_A, ET_IP, 60, 0, 1, 3, 1'b0);
        wait_beats(19, 200);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(200);
        chk("t6_frames", frames_sent, 3);
        chk("t6_done_pulses", done_cnt, 1);
        chk("t6_tuser_frames", tuser_acc, 1);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_idle", busy, 0);

        // start and stop together: exactly one frame
        model_frame(SRC_A, BCAST, ET_IP, 100, 1, 1);
        start_run(SRC_A, BCAST, ET_IP, 100, 0, 0, 1, 1'b1);
        wait_done(100);
        chk("t7_frames", frames_sent, 1);
        chk("t7_bytes", bytes_sent, 100);
        chk("t7_tuser_frames", tuser_acc, 1);
        chk("t7_queue_empty", exp_q.size(), 0);

        // reset in the middle of frame 2
        for (int n = 1; n <= 3; n++) model_frame(BCAST, SRC_A, ET_IP, 60, n, 0);
        start_run(BCAST, SRC_A, ET_IP, 60, 0, 0, 0, 1'b0);
        wait_beats(11, 100);
        chk("t8_frames_before_reset", frames_sent, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_rst_tvalid", tvalid, 0);
        chk("t8_rst_frames", frames_sent, 0);
        chk("t8_rst_bytes", bytes_sent, 0);
        chk("t8_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean frame after reset
        model_frame(48'h0200_0000_0001, 48'hAABB_CCDD_EEFF, 16'h86DD, 75, 1, 0);
        start_run(48'h0200_0000_0001, 48'hAABB_CCDD_EEFF, 16'h86DD, 75, 1, 0, 0, 1'b0);
        wait_done(100);
        chk("t9_beat0", first_data, 64'hBBAA010000000002);
        chk("t9_beats", beats_acc, 10);
        chk("t9_last_keep", last_keep, 8'h07);
        chk("t9_frames", frames_sent, 1);
        chk("t9_bytes", bytes_sent, 75);
        chk("t9_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
